// File: rtl/i2c_tx_feeder_pkg.sv
// Shared serial-controller definitions: feeder state encoding and FIFO entry layout.
package i2c_tx_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_ARMED     = 2'b01,
        ST_SENDING   = 2'b10,
        ST_WAIT_DONE = 2'b11
    } feeder_state_t;

    localparam int I2C_ENTRY_W  = 9;
    localparam int I2C_LAST_BIT = 8;

endpackage

// File: rtl/i2c_byte_fifo.sv
// Synchronous show-ahead FIFO; the head entry is visible combinationally on rd_entry.
module i2c_byte_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int WIDTH  = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [WIDTH-1:0]  wr_entry,
    input  logic              pop,
    output logic [WIDTH-1:0]  rd_entry,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full     = (count == (ADDR_W + 1)'(DEPTH));
    assign empty    = (count == '0);
    assign rd_entry = mem[rd_ptr];

    // A push while full is still taken when the head leaves on the same edge.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/i2c_tx_feeder.sv
// Byte-framing buffer ahead of the I2C byte transmitter; releases a transaction
// only once every byte of it is buffered.
module i2c_tx_feeder
    import i2c_tx_feeder_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] wr_data,
    input  logic       wr_last,
    input  logic       wr_en,
    output logic       full,
    output logic [7:0] data,
    output logic       data_ready,
    output logic       en,
    input  logic       data_req,
    input  logic       done,
    output logic       busy,
    output logic       overflow,
    output logic       proto_err
);

    // Handshake: data is valid while data_ready=1; a data_req pulse consumes the
    // head byte on the edge ending that cycle. done closes the transaction.

    feeder_state_t          state;
    feeder_state_t          state_next;
    logic [I2C_ENTRY_W-1:0] head;
    logic [ADDR_W:0]        fifo_count;
    logic [ADDR_W:0]        txn_count;
    logic                   fifo_empty;
    logic                   head_last;
    logic                   sending;
    logic                   pop;
    logic                   push_ok;
    logic                   ready_next;
    logic                   en_next;
    logic                   busy_next;

    assign data      = head[7:0];
    assign head_last = head[I2C_LAST_BIT];
    assign sending   = (state == ST_ARMED) || (state == ST_SENDING);
    assign pop       = data_req && sending && !fifo_empty;
    assign push_ok   = wr_en && (!full || pop);

    i2c_byte_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WIDTH  (I2C_ENTRY_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (wr_en),
        .wr_entry ({wr_last, wr_data}),
        .pop      (pop),
        .rd_entry (head),
        .count    (fifo_count),
        .full     (full),
        .empty    (fifo_empty)
    );

    // Registered outputs are loaded from the next-state decode so they track state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            data_ready <= 1'b0;
            en         <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            data_ready <= ready_next;
            en         <= en_next;
            busy       <= busy_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:      if (txn_count != '0) state_next = ST_ARMED;
            ST_ARMED:     if (pop) state_next = head_last ? ST_WAIT_DONE : ST_SENDING;
            ST_SENDING:   if (pop && head_last) state_next = ST_WAIT_DONE;
            ST_WAIT_DONE: if (done) state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ready_next = (state_next == ST_ARMED) || (state_next == ST_SENDING);
        en_next    = ready_next;
        busy_next  = (state_next != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txn_count <= '0;
            overflow  <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            case ({push_ok && wr_last, pop && head_last})
                2'b10:   txn_count <= txn_count + 1'b1;
                2'b01:   txn_count <= txn_count - 1'b1;
                default: txn_count <= txn_count;
            endcase
            if (wr_en && !push_ok) overflow <= 1'b1;
            if ((data_req && (!sending || fifo_count == '0)) ||
                (done && state != ST_WAIT_DONE)) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/i2c_tx_feeder.md
# i2c_tx_feeder

Byte-framing buffer that sits directly upstream of the I2C byte transmitter in the serial controller. It accepts write bytes from the host-side command decoder, with an end-of-transaction flag, and stores them in a small FIFO. It presents them to the transmitter over the `data` / `data_ready` / `data_req` / `done` handshake. A transaction is released only when all of its bytes are buffered, so the transmitter never issues a premature STOP through underrun.

## Interface
- `DEPTH`, 16: FIFO entries; must be a power of two, 4 minimum.
- `ADDR_W`, 4: log2(`DEPTH`).
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_data`  in  8  byte to enqueue.
- `wr_last`  in  1  marks `wr_data` as the final byte of a transaction.
- `wr_en`  in  1  push strobe, one byte per cycle.
- `full`  out  1  FIFO holds `DEPTH` entries.
- `data`  out  8  head byte to the transmitter.
- `data_ready`  out  1  another byte of the current transaction is available.
- `en`  out  1  transmitter enable.
- `data_req`  in  1  one-cycle pulse from the transmitter; it samples `data` in this cycle.
- `done`  in  1  one-cycle pulse from the transmitter after STOP.
- `busy`  out  1  a transaction is in flight (ARMED, SENDING or WAIT_DONE).
- `overflow`  out  1  sticky: a push was dropped while full.
- `proto_err`  out  1  sticky: `data_req` arrived with no byte available, or `done` arrived outside WAIT_DONE.

## Operation
- FIFO entry is 9 bits: {last, byte}. Reads are show-ahead: `data` is the head byte combinationally from storage. `count` is ADDR_W+1 bits.
- `txn_count` (ADDR_W+1 bits) counts complete transactions in the FIFO.
  - It increments on an accepted push with `wr_last`=1.
  - It decrements when a popped entry has last=1.
  - Simultaneous increment and decrement leaves it unchanged.
- Push with `full`=1: the byte is dropped, `overflow` is set, and `txn_count` is unchanged. Push and pop in the same cycle while full: the push is accepted.
- State machine:
  - **IDLE**: `data_ready`=0, `en`=0. If `txn_count`≠0, go to ARMED.
  - **ARMED**: `data_ready`=1, `en`=1. On `data_req`, pop the head entry. If it is last, go to WAIT_DONE; otherwise go to SENDING.
  - **SENDING**: `data_ready`=1, `en`=1. On `data_req`, pop the head entry. If it is last, go to WAIT_DONE.
  - **WAIT_DONE**: `data_ready`=0, `en`=0. On `done`, go to IDLE.
- `data_req` in IDLE or WAIT_DONE, or with the FIFO empty: no pop, set `proto_err`.
- `done` outside WAIT_DONE: ignored, set `proto_err`.
- Sticky flags clear only on `rst`.

## Timing
- Reset values: `data_ready`=0, `en`=0, `busy`=0, `overflow`=0, `proto_err`=0, `full`=0. FIFO pointers, `count` and `txn_count` are 0; state is IDLE. `data` is don't-care while empty.
- `data_ready`, `en`, `busy` and the flags are registered. The FIFO pop and state update occur on the edge that ends the `data_req` cycle.
- Latency: a push with `wr_last` registered at edge N gives `txn_count`=1 after N and `data_ready`=1 after N+1.
- `data_ready` falls on the same edge that pops the last byte, well before the transmitter's next end-of-byte sample (≥ 600 cycles later).
- Back-to-back transactions: IDLE→ARMED takes one cycle after `done`, if `txn_count`≠0.
- Reset mid-transaction: all state clears immediately. The transmitter is not reset by this block; the system `rst` must cover both.

## Structure
- The shared serial-controller package holds:
  - the state encoding (IDLE=2'b00, ARMED=2'b01, SENDING=2'b10, WAIT_DONE=2'b11);
  - `I2C_ENTRY_W`=9;
  - the last-flag bit index (8).
- One sub-module, `i2c_byte_fifo`: synchronous show-ahead FIFO parameterised by `DEPTH`/width, exposing `count`, `full` and `empty`. The FSM and `txn_count` live in the top level.

## Test plan
- **Single transaction**: push 8'hA0, 8'h10, 8'h55 (last on 8'h55).
  - Expect `data_ready`=1 two cycles after the last push.
  - On three `data_req` pulses, `data` reads A0, 10, 55.
  - `data_ready` is 0 after the third pop; `done` returns to IDLE.
- **Partial transaction held**: push 8'hA0 and 8'h01 without last. Expect `data_ready` to stay 0 for 100 cycles. Push 8'h02 with last; expect `data_ready` to rise.
- **Back-to-back**: queue two 2-byte transactions. Expect `data_ready` 0 during WAIT_DONE, then 1 exactly 2 cycles after `done`; the second pair is delivered in order.
- **Overflow**: 16 pushes fill the FIFO, then a 17th push of 8'hFF. Expect `full`=1, `overflow`=1, `count`=16, and 8'hFF never output.
- **Protocol errors**: `data_req` in IDLE with the FIFO empty, then `done` in IDLE. Expect `proto_err`=1, no pointer change, `data_ready`=0.
- **Reset mid-transfer**: assert `rst` in SENDING after one pop. Expect all outputs at reset values the same cycle, and a fresh 1-byte transaction afterwards outputs correctly.
